issue_rs: RTL and testbench

//  Reservation station directly downstream of the rename stage. Accepts up to IW renamed uops per cycle
//  and tracks source-operand readiness through busytable snapshots and writeback wakeups. Selects the

---
 rtl/issue_rs.sv | 188 ++++++++++++++++++
 tb/tb_issue_rs.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/issue_rs.sv
// issue_rs: reservation station that tracks operand readiness and issues the oldest ready uop to one FU
// Optional: define ISSUE_RS_PERF_EN to add the perf_full_cyc / perf_fu_stall_cyc counters
module issue_rs #(
   parameter int CONFIG_P_ISSUE_WIDTH     = 1,
   parameter int CONFIG_P_RS_DEPTH        = 3,
   parameter int CONFIG_P_WRITEBACK_WIDTH = 1,
   parameter int PLD_W                    = 64,
   parameter int PRF_AW                   = 6,
   localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH,
   localparam int CD = CONFIG_P_RS_DEPTH,
   localparam int D  = 1 << CONFIG_P_RS_DEPTH,
   localparam int WW = 1 << CONFIG_P_WRITEBACK_WIDTH
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   issue_p_ce,
   input  logic [IW-1:0]          issue_push,
   input  logic [IW*PRF_AW-1:0]   issue_prs1,
   input  logic [IW-1:0]          issue_prs1_re,
   input  logic [IW*PRF_AW-1:0]   issue_prs2,
   input  logic [IW-1:0]          issue_prs2_re,
   input  logic [IW*PLD_W-1:0]    issue_payload,
   input  logic [(1<<PRF_AW)-1:0] busytable,
   input  logic [WW*PRF_AW-1:0]   prf_WADDR,
   input  logic [WW-1:0]          prf_WE,
   output logic [IW-1:0]          issue_ready,
   output logic                   fu_valid,
   input  logic                   fu_ready,
   output logic [PRF_AW-1:0]      fu_prs1,
   output logic [PRF_AW-1:0]      fu_prs2,
   output logic [PLD_W-1:0]       fu_payload
`ifdef ISSUE_RS_PERF_EN
   ,
   output logic [31:0]            perf_full_cyc,
   output logic [31:0]            perf_fu_stall_cyc
`endif
);
   logic [D-1:0]      r_vld, r_rdy1, r_rdy2;
   logic [PRF_AW-1:0] r_prs1 [D];
   logic [PRF_AW-1:0] r_prs2 [D];
   logic [PLD_W-1:0]  r_pld [D];
   logic [D-1:0]      r_older [D];
   logic              r_fu_valid;
   logic [PRF_AW-1:0] r_fu_prs1, r_fu_prs2;
   logic [PLD_W-1:0]  r_fu_pld;
   logic [D-1:0]      w_older_n [D];
   logic [D-1:0]      w_enq [IW];
   logic [D-1:0]      w_new, w_wk1, w_wk2, w_cand, w_pick, w_deq;
   logic [IW-1:0]     w_push, w_lrdy1, w_lrdy2, w_ovf;
   logic [PRF_AW-1:0] w_lprs1 [IW];
   logic [PRF_AW-1:0] w_lprs2 [IW];
   logic [CD:0]       w_free;
   logic              w_ld, w_any;
   logic [PRF_AW-1:0] w_s_prs1, w_s_prs2;
   logic [PLD_W-1:0]  w_s_pld;
   // lane decode; a source is ready if unused, not busy, or written back this very cycle
   always_comb begin
      w_push = {IW{issue_p_ce & ~flush}} & issue_push;
      for (int k = 0; k < IW; k++) begin
         w_lprs1[k] = issue_prs1[k*PRF_AW +: PRF_AW];
         w_lprs2[k] = issue_prs2[k*PRF_AW +: PRF_AW];
         w_lrdy1[k] = ~issue_prs1_re[k] | ~busytable[w_lprs1[k]];
         w_lrdy2[k] = ~issue_prs2_re[k] | ~busytable[w_lprs2[k]];
         for (int w = 0; w < WW; w++) begin
            w_lrdy1[k] = w_lrdy1[k] | (prf_WE[w] & (prf_WADDR[w*PRF_AW +: PRF_AW] == w_lprs1[k]));
            w_lrdy2[k] = w_lrdy2[k] | (prf_WE[w] & (prf_WADDR[w*PRF_AW +: PRF_AW] == w_lprs2[k]));
         end
      end
   end
   // lane k takes the k-th lowest free entry; the free count comes from registered valid bits
   always_comb begin
      w_free = '0;
      for (int k = 0; k < IW; k++) w_enq[k] = '0;
      for (int i = 0; i < D; i++)
         if (!r_vld[i]) begin
            for (int k = 0; k < IW; k++)
               if (w_free == (CD+1)'(k)) w_enq[k][i] = w_push[k];
            w_free = w_free + 1'b1;
         end
      w_new = '0;
      for (int k = 0; k < IW; k++) begin
         w_new     = w_new | w_enq[k];
         w_ovf[k]  = w_push[k] & ~|w_enq[k];
      end
      issue_ready = {IW{w_free >= (CD+1)'(IW)}};
   end
   // wakeup match of resident sources against the writeback ports
   always_comb begin
      for (int i = 0; i < D; i++) begin
         w_wk1[i] = 1'b0;
         w_wk2[i] = 1'b0;
         for (int w = 0; w < WW; w++) begin
            w_wk1[i] = w_wk1[i] | (prf_WE[w] & (prf_WADDR[w*PRF_AW +: PRF_AW] == r_prs1[i]));
            w_wk2[i] = w_wk2[i] | (prf_WE[w] & (prf_WADDR[w*PRF_AW +: PRF_AW] == r_prs2[i]));
         end
      end
   end
   // oldest-ready select: a candidate wins when no other candidate is older than it
   always_comb begin
      w_cand   = r_vld & r_rdy1 & r_rdy2;
      w_any    = |w_cand;
      w_ld     = ~r_fu_valid | fu_ready;
      w_s_prs1 = '0;
      w_s_prs2 = '0;
      w_s_pld  = '0;
      for (int i = 0; i < D; i++) begin
         w_pick[i] = w_cand[i] & ~|(r_older[i] & w_cand);
         if (w_pick[i]) begin
            w_s_prs1 = r_prs1[i];
            w_s_prs2 = r_prs2[i];
            w_s_pld  = r_pld[i];
         end
      end
      w_deq = w_ld ? w_pick : '0;
   end
   // age matrix update: row i bit j set means entry j is older than entry i
   always_comb begin
      for (int i = 0; i < D; i++)
         for (int j = 0; j < D; j++) begin
            w_older_n[i][j] = r_older[i][j] & ~w_new[j];
            for (int k = 0; k < IW; k++)
               if (w_enq[k][i]) begin
                  w_older_n[i][j] = r_vld[j];
                  for (int m = 0; m < k; m++)
                     if (w_enq[m][j]) w_older_n[i][j] = 1'b1;
               end
         end
   end
   // control state: valid bits, age matrix and the registered FU port
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_vld      <= '0;
         r_fu_valid <= 1'b0;
         r_fu_prs1  <= '0;
         r_fu_prs2  <= '0;
         r_fu_pld   <= '0;
         for (int i = 0; i < D; i++) r_older[i] <= '0;
      end else if (flush) begin
         r_vld      <= '0;
         r_fu_valid <= 1'b0;
      end else begin
         r_vld   <= (r_vld & ~w_deq) | w_new;
         r_older <= w_older_n;
         if (w_ld) r_fu_valid <= w_any;
         if (w_ld & w_any) begin
            r_fu_prs1 <= w_s_prs1;
            r_fu_prs2 <= w_s_prs2;
            r_fu_pld  <= w_s_pld;
         end
      end
   // entry payload and readiness; meaningless while the entry is invalid, so no reset
   always_ff @(posedge clk)
      for (int i = 0; i < D; i++)
         if (w_new[i]) begin
            for (int k = 0; k < IW; k++)
               if (w_enq[k][i]) begin
                  r_prs1[i] <= w_lprs1[k];
                  r_prs2[i] <= w_lprs2[k];
                  r_pld[i]  <= issue_payload[k*PLD_W +: PLD_W];
                  r_rdy1[i] <= w_lrdy1[k];
                  r_rdy2[i] <= w_lrdy2[k];
               end
         end else begin
            if (w_wk1[i]) r_rdy1[i] <= 1'b1;
            if (w_wk2[i]) r_rdy2[i] <= 1'b1;
         end
   assign fu_valid   = r_fu_valid;
   assign fu_prs1    = r_fu_prs1;
   assign fu_prs2    = r_fu_prs2;
   assign fu_payload = r_fu_pld;
   // rename must never push into a full station
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) w_ovf == '0);
`ifdef ISSUE_RS_PERF_EN
   logic [31:0] r_perf_full, r_perf_stall;
   // free-running wrapping counters, untouched by flush
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_perf_full  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (!issue_ready[0]) r_perf_full <= r_perf_full + 1'b1;
         if (r_fu_valid & ~fu_ready) r_perf_stall <= r_perf_stall + 1'b1;
      end
   assign perf_full_cyc     = r_perf_full;
   assign perf_fu_stall_cyc = r_perf_stall;
`endif
endmodule

// File: tb/tb_issue_rs.sv
// tb_issue_rs: directed checks of enqueue, wakeup, age order, full/stall/flush for issue_rs
module tb_issue_rs;
   localparam int IW = 2, PA = 6, PW = 64, WW = 2;
   logic clk = 1'b0, rst = 1'b0, flush = 1'b0, issue_p_ce = 1'b0, fu_ready = 1'b0;
   logic [IW-1:0] issue_push = '0, issue_prs1_re = '0, issue_prs2_re = '0, issue_ready;
   logic [IW*PA-1:0] issue_prs1 = '0, issue_prs2 = '0;
   logic [IW*PW-1:0] issue_payload = '0;
   logic [(1<<PA)-1:0] busytable = '0;
   logic [WW*PA-1:0] prf_WADDR = '0;
   logic [WW-1:0] prf_WE = '0;
   logic fu_valid;
   logic [PA-1:0] fu_prs1, fu_prs2;
   logic [PW-1:0] fu_payload;
`ifdef ISSUE_RS_PERF_EN
   logic [31:0] perf_full_cyc, perf_fu_stall_cyc;
`endif
   int n_vec = 0, n_err = 0;
   issue_rs dut (
      .clk(clk), .rst(rst), .flush(flush), .issue_p_ce(issue_p_ce), .issue_push(issue_push),
      .issue_prs1(issue_prs1), .issue_prs1_re(issue_prs1_re), .issue_prs2(issue_prs2),
      .issue_prs2_re(issue_prs2_re), .issue_payload(issue_payload), .busytable(busytable),
      .prf_WADDR(prf_WADDR), .prf_WE(prf_WE), .issue_ready(issue_ready), .fu_valid(fu_valid),
      .fu_ready(fu_ready), .fu_prs1(fu_prs1), .fu_prs2(fu_prs2), .fu_payload(fu_payload)
`ifdef ISSUE_RS_PERF_EN
      , .perf_full_cyc(perf_full_cyc), .perf_fu_stall_cyc(perf_fu_stall_cyc)
`endif
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle;
      issue_p_ce = 0; issue_push = '0; issue_prs1_re = '0; issue_prs2_re = '0; prf_WE = '0; flush = 0;
   endtask
   task automatic push(input int ln, input logic [PA-1:0] p1, input logic r1,
                       input logic [PA-1:0] p2, input logic r2, input logic [PW-1:0] pl);
      issue_p_ce = 1; issue_push[ln] = 1;
      issue_prs1[ln*PA +: PA] = p1; issue_prs1_re[ln] = r1;
      issue_prs2[ln*PA +: PA] = p2; issue_prs2_re[ln] = r2;
      issue_payload[ln*PW +: PW] = pl;
   endtask
   task automatic wb(input int port, input logic [PA-1:0] a);
      prf_WE[port] = 1; prf_WADDR[port*PA +: PA] = a;
   endtask
   task automatic test_reset;
      idle; rst = 0; tick; tick;
      n_vec++; if (fu_valid !== 1'b0) begin n_err++; $display("FAIL rst_fu_valid got %0b want 0", fu_valid); end
      n_vec++; if (issue_ready !== 2'b11) begin n_err++; $display("FAIL rst_issue_ready got %b want 11", issue_ready); end
      n_vec++; if (fu_prs1 !== '0 || fu_prs2 !== '0) begin n_err++; $display("FAIL rst_fu_prs got %0d/%0d want 0/0", fu_prs1, fu_prs2); end
      n_vec++; if (fu_payload !== '0) begin n_err++; $display("FAIL rst_payload got %h want 0", fu_payload); end
      rst = 1; tick;
   endtask
   task automatic test_latency;
      fu_ready = 1; push(0, 5, 1, 6, 1, 64'h100); tick; idle;
      n_vec++; if (fu_valid !== 1'b0) begin n_err++; $display("FAIL lat_early got %0b want 0", fu_valid); end
      tick;
      n_vec++; if (fu_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid got %0b want 1", fu_valid); end
      n_vec++; if (fu_prs1 !== 6'd5 || fu_prs2 !== 6'd6) begin n_err++; $display("FAIL lat_prs got %0d/%0d want 5/6", fu_prs1, fu_prs2); end
      n_vec++; if (fu_payload !== 64'h100) begin n_err++; $display("FAIL lat_payload got %h want 100", fu_payload); end
      tick;
      n_vec++; if (fu_valid !== 1'b0) begin n_err++; $display("FAIL lat_drain got %0b want 0", fu_valid); end
   endtask
   task automatic test_wakeup;
      busytable[9] = 1; push(0, 9, 1, 0, 0, 64'h200); tick; idle; tick;
      n_vec++; if (fu_valid !== 1'b0) begin n_err++; $display("FAIL wk_before got %0b want 0", fu_valid); end
      wb(0, 9); tick; idle;
      n_vec++; if (fu_valid !== 1'b0) begin n_err++; $display("FAIL wk_same got %0b want 0", fu_valid); end
      tick;
      n_vec++; if (fu_valid !== 1'b1 || fu_payload !== 64'h200) begin n_err++; $display("FAIL wk_issue got %0b/%h want 1/200", fu_valid, fu_payload); end
      busytable[9] = 0; tick;
   endtask
   task automatic test_age;
      busytable[20] = 1; push(0, 20, 1, 0, 0, 64'hA); tick; idle;
      push(0, 21, 1, 0, 0, 64'hB); tick; idle;
      wb(1, 20); tick; idle;
      n_vec++; if (fu_valid !== 1'b1 || fu_payload !== 64'hB) begin n_err++; $display("FAIL age_first got %0b/%h want 1/b", fu_valid, fu_payload); end
      tick;
      n_vec++; if (fu_valid !== 1'b1 || fu_payload !== 64'hA) begin n_err++; $display("FAIL age_second got %0b/%h want 1/a", fu_valid, fu_payload); end
      busytable[20] = 0; tick;
      push(0, 0, 0, 0, 0, 64'h10); push(1, 0, 0, 0, 0, 64'h11); tick; idle; tick;
      n_vec++; if (fu_valid !== 1'b1 || fu_payload !== 64'h10) begin n_err++; $display("FAIL lane0_first got %0b/%h want 1/10", fu_valid, fu_payload); end
      tick;
      n_vec++; if (fu_valid !== 1'b1 || fu_payload !== 64'h11) begin n_err++; $display("FAIL lane1_second got %0b/%h want 1/11", fu_valid, fu_payload); end
      tick;
      n_vec++; if (fu_valid !== 1'b0) begin n_err++; $display("FAIL age_drain got %0b want 0", fu_valid); end
   endtask
   task automatic test_full;
`ifdef ISSUE_RS_PERF_EN
      logic [31:0] p0;
`endif
      logic [PA-1:0] a, b;
      busytable[37:30] = '1;
      for (int c = 0; c < 4; c++) begin
         a = 6'(30 + 2*c); b = 6'(31 + 2*c);
         push(0, a, 1, 0, 0, 64'(a)); push(1, b, 1, 0, 0, 64'(b)); tick; idle;
      end
      n_vec++; if (issue_ready !== 2'b00) begin n_err++; $display("FAIL full_ready got %b want 00", issue_ready); end
`ifdef ISSUE_RS_PERF_EN
      p0 = perf_full_cyc;
`endif
      wb(0, 30); tick; idle; tick;
      n_vec++; if (fu_valid !== 1'b1 || fu_prs1 !== 6'd30) begin n_err++; $display("FAIL full_issue30 got %0b/%0d want 1/30", fu_valid, fu_prs1); end
      tick;
      n_vec++; if (issue_ready !== 2'b00) begin n_err++; $display("FAIL full_7res got %b want 00", issue_ready); end
      wb(1, 31); tick; idle; tick;
      n_vec++; if (fu_valid !== 1'b1 || fu_prs1 !== 6'd31) begin n_err++; $display("FAIL full_issue31 got %0b/%0d want 1/31", fu_valid, fu_prs1); end
      n_vec++; if (issue_ready !== 2'b11) begin n_err++; $display("FAIL full_6res got %b want 11", issue_ready); end
`ifdef ISSUE_RS_PERF_EN
      n_vec++; if (perf_full_cyc !== p0 + 32'd5) begin n_err++; $display("FAIL perf_full got %0d want %0d", perf_full_cyc, p0 + 32'd5); end
`endif
      flush = 1; tick; idle; busytable = '0; tick;
      n_vec++; if (issue_ready !== 2'b11 || fu_valid !== 1'b0) begin n_err++; $display("FAIL full_flush got %b/%0b want 11/0", issue_ready, fu_valid); end
   endtask
   task automatic test_stall;
`ifdef ISSUE_RS_PERF_EN
      logic [31:0] s0;
`endif
      fu_ready = 0; push(0, 1, 0, 2, 0, 64'h50); push(1, 3, 0, 4, 0, 64'h51); tick; idle; tick;
      n_vec++; if (fu_valid !== 1'b1 || fu_payload !== 64'h50) begin n_err++; $display("FAIL stall_first got %0b/%h want 1/50", fu_valid, fu_payload); end
`ifdef ISSUE_RS_PERF_EN
      s0 = perf_fu_stall_cyc;
`endif
      for (int c = 0; c < 3; c++) begin
         tick;
         n_vec++; if (fu_valid !== 1'b1 || fu_payload !== 64'h50 || fu_prs1 !== 6'd1 || fu_prs2 !== 6'd2) begin
            n_err++; $display("FAIL stall_hold%0d got %0b/%h/%0d/%0d want 1/50/1/2", c, fu_valid, fu_payload, fu_prs1, fu_prs2); end
      end
      flush = 1; tick; idle;
      n_vec++; if (fu_valid !== 1'b0 || issue_ready !== 2'b11) begin n_err++; $display("FAIL flush_out got %0b/%b want 0/11", fu_valid, issue_ready); end
`ifdef ISSUE_RS_PERF_EN
      n_vec++; if (perf_fu_stall_cyc !== s0 + 32'd4) begin n_err++; $display("FAIL perf_stall got %0d want %0d", perf_fu_stall_cyc, s0 + 32'd4); end
`endif
      fu_ready = 1; tick;
      n_vec++; if (fu_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty got %0b want 0", fu_valid); end
   endtask
   task automatic test_same_cycle_wb;
      busytable[12] = 1; push(0, 12, 1, 0, 0, 64'h60); wb(1, 12); tick; idle; tick;
      n_vec++; if (fu_valid !== 1'b1 || fu_payload !== 64'h60 || fu_prs1 !== 6'd12) begin
         n_err++; $display("FAIL same_cycle_wb got %0b/%h/%0d want 1/60/12", fu_valid, fu_payload, fu_prs1); end
      busytable[12] = 0; tick;
   endtask
   initial begin
      test_reset;
      test_latency;
      test_wakeup;
      test_age;
      test_full;
      test_stall;
      test_same_cycle_wb;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
